// File: rtl/slice_chain_adder.sv
// Sequential W-bit adder that pushes one 3-bit slice per cycle through a single
// 3-bit full adder, rippling the carry through a register, behind valid/ready ports.

module fa_3bit (
   input  logic [2:0] i_a,
   input  logic [2:0] i_b,
   input  logic       i_cin,
   output logic [2:0] o_sum,
   output logic       o_cout
);
   logic [3:0] w_total;

   assign w_total = 4'(i_a) + 4'(i_b) + 4'(i_cin);
   assign o_sum   = w_total[2:0];
   assign o_cout  = w_total[3];
endmodule

module slice_chain_adder #(
   parameter  int unsigned NSLICES = 4,
   localparam int unsigned W       = 3 * NSLICES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         busy
);
   localparam int unsigned IW = (NSLICES > 1) ? $clog2(NSLICES) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_acc;
   logic [W-1:0]  r_sum;
   logic          r_carry;
   logic          r_cout;
   logic [IW-1:0] r_idx;
   logic          r_out_valid;
   logic          r_busy;

   logic [2:0]    w_sl_a;
   logic [2:0]    w_sl_b;
   logic [2:0]    w_fa_sum;
   logic          w_fa_cout;
   logic          w_last;
   logic [W-1:0]  w_acc_nxt;

   // Current slice selection and accumulator merge; shifts keep index widths trivial.
   always_comb begin
      w_sl_a    = 3'(r_a >> (3 * r_idx));
      w_sl_b    = 3'(r_b >> (3 * r_idx));
      w_last    = (r_idx == IW'(NSLICES - 1));
      w_acc_nxt = (r_acc & ~(W'(3'b111) << (3 * r_idx))) | (W'(w_fa_sum) << (3 * r_idx));
   end

   fa_3bit u_fa (
      .i_a    (w_sl_a),
      .i_b    (w_sl_b),
      .i_cin  (r_carry),
      .o_sum  (w_fa_sum),
      .o_cout (w_fa_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath: result registers load only on the RUN->DONE edge so they hold in IDLE.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a         <= '0;
         r_b         <= '0;
         r_acc       <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_cout      <= 1'b0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_out_valid <= (w_state_nxt == S_DONE);
         r_busy      <= (w_state_nxt != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= cin;
                  r_acc   <= '0;
                  r_idx   <= '0;
               end
            end
            S_RUN: begin
               r_acc   <= w_acc_nxt;
               r_carry <= w_fa_cout;
               if (w_last) begin
                  r_sum  <= w_acc_nxt;
                  r_cout <= w_fa_cout;
               end else begin
                  r_idx  <= r_idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE) && rst_n;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign sum       = r_sum;
   assign cout      = r_cout;
endmodule

// File: tb/tb_slice_chain_adder.sv
// Directed bench for slice_chain_adder: a 4-slice instance and a 1-slice instance,
// expected results queued at accept and compared when the result is taken.

module tb_slice_chain_adder;
   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   // 4-slice instance
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [11:0] a, b, sum;
   // 1-slice instance
   logic        in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1, busy1;
   logic [2:0]  a1, b1, sum1;

   int          errors = 0;
   int          checks = 0;
   logic [12:0] q4[$];
   logic [3:0]  q1[$];

   slice_chain_adder #(.NSLICES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .busy(busy)
   );

   slice_chain_adder #(.NSLICES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
      .sum(sum1), .cout(cout1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Present operands at a negedge, let the next posedge accept them.
   task automatic accept4(input logic [11:0] av, input logic [11:0] bv, input logic cv);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      chk("accept_in_ready", 32'(in_ready), 32'd1);
      q4.push_back(13'(av) + 13'(bv) + 13'(cv));
      @(negedge clk);
      in_valid = 1'b0;
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_in_ready", 32'(in_ready), 32'd0);
   endtask

   task automatic wait_valid4(input string tag);
      int cyc = 0;
      while (out_valid !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk(tag, 32'(cyc), 32'd4);
   endtask

   task automatic pop4(input string tag);
      logic [12:0] exp_v;
      exp_v = '0;
      out_ready = 1'b1;
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      if (q4.size() == 0) chk({tag, "_scoreboard_empty"}, 32'(q4.size()), 32'd1);
      else exp_v = q4.pop_front();
      chk({tag, "_sum"},  32'(sum),  32'(exp_v[11:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(exp_v[12]));
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle_valid"},    32'(out_valid), 32'd0);
      chk({tag, "_idle_in_ready"}, 32'(in_ready),  32'd1);
      chk({tag, "_idle_busy"},     32'(busy),      32'd0);
      chk({tag, "_idle_sum_held"}, 32'(sum),       32'(exp_v[11:0]));
   endtask

   initial begin
      logic [12:0] r;
      logic [3:0]  e1;
      rst_n = 1'b0;
      in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b1;

      // Reset
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready_low", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_sum",       32'(sum),       32'd0);
      chk("rst_cout",      32'(cout),      32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // Carry across a slice boundary
      accept4(12'h0FF, 12'h001, 1'b0);
      wait_valid4("lat_0ff");
      pop4("op_0ff");

      // Carry ripples through every slice into cout
      accept4(12'hFFF, 12'h000, 1'b1);
      wait_valid4("lat_fff");
      pop4("op_fff");

      // Backpressure with an ignored in_valid
      accept4(12'h7A5, 12'h35C, 1'b0);
      wait_valid4("lat_7a5");
      for (int i = 0; i < 5; i++) begin
         a = 12'h001; b = 12'h001; in_valid = 1'b1;
         chk("bp_valid",    32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready),  32'd0);
         chk("bp_sum",      32'(sum),       32'hB01);
         chk("bp_cout",     32'(cout),      32'd0);
         @(negedge clk);
      end
      in_valid = 1'b0;
      pop4("op_7a5");

      // Reset while RUN at idx=2 aborts silently
      a = 12'hABC; b = 12'h123; cin = 1'b1; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_busy",  32'(busy),      32'd0);
      chk("abort_sum",   32'(sum),       32'd0);
      chk("abort_cout",  32'(cout),      32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("abort_no_valid", 32'(out_valid), 32'd0);
      end
      chk("abort_in_ready", 32'(in_ready), 32'd1);
      accept4(12'h001, 12'h001, 1'b0);
      wait_valid4("lat_after_abort");
      pop4("op_after_abort");

      // A few pseudo-random operands
      for (int i = 0; i < 4; i++) begin
         r = 13'($urandom);
         accept4(12'($urandom), 12'($urandom), r[0]);
         wait_valid4("lat_rand");
         repeat (i) @(negedge clk);
         pop4("op_rand");
      end

      // Single-slice instance: exhaustive 3-bit operands
      for (int i = 0; i < 128; i++) begin
         e1 = 7'(i) >> 0 == 0 ? 4'd0 : 4'd0;
         a1 = 3'(i); b1 = 3'(i >> 3); cin1 = 1'(i >> 6);
         chk("s1_in_ready", 32'(in_ready1), 32'd1);
         q1.push_back(4'(a1) + 4'(b1) + 4'(cin1));
         in_valid1 = 1'b1;
         @(negedge clk);
         in_valid1 = 1'b0;
         chk("s1_not_yet", 32'(out_valid1), 32'd0);
         @(negedge clk);
         chk("s1_valid", 32'(out_valid1), 32'd1);
         if (q1.size() != 0) e1 = q1.pop_front();
         chk("s1_result", 32'({cout1, sum1}), 32'(e1));
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
